// File: rtl/rename_ckpt.sv
// Single-issue register rename with a circular free list and branch checkpoints.
// A mispredict restores the map, the free-list read pointer and the ROB counter
// from a checkpoint in one cycle.
module rename_ckpt #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 128,
  parameter int unsigned PREG_W    = $clog2(PHYS_REGS),
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned NUM_CKPT  = 4,
  parameter int unsigned CKPT_W    = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [PREG_W-1:0] ps1,
  output logic [PREG_W-1:0] ps2,
  output logic [PREG_W-1:0] pd_new,
  output logic [PREG_W-1:0] pd_old,
  output logic [31:0]       imm_out,
  output logic [ROB_W-1:0]  rob_tag,
  output logic              br_valid,
  output logic [CKPT_W-1:0] br_tag,
  input  logic              commit_valid,
  input  logic [PREG_W-1:0] commit_pd_old,
  input  logic              resolve_valid,
  input  logic              mispredict,
  input  logic [CKPT_W-1:0] mispredict_tag
);

  localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned FL_AW    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int unsigned FL_CW    = $clog2(FL_DEPTH + 1);
  localparam int unsigned CP_W     = CKPT_W + 1;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Free-list pointer: index into the circular buffer plus a lap bit.
  typedef struct packed {
    logic             wrap;
    logic [FL_AW-1:0] idx;
  } fl_ptr_t;

  // Advance a free-list pointer, toggling the lap bit when the index wraps.
  function automatic fl_ptr_t fl_inc(input fl_ptr_t p);
    fl_ptr_t r;
    r = p;
    if (p.idx == FL_AW'(FL_DEPTH - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + FL_AW'(1);
    end
    return r;
  endfunction

  logic [PREG_W-1:0] map_q    [ARCH_REGS];
  logic [PREG_W-1:0] map_nxt  [ARCH_REGS];
  logic [PREG_W-1:0] fl_mem   [FL_DEPTH];
  fl_ptr_t           fl_rd_q, fl_wr_q, fl_rd_nxt;
  logic [ROB_W-1:0]  rob_q;

  logic [PREG_W-1:0] ckpt_map [NUM_CKPT][ARCH_REGS];
  fl_ptr_t           ckpt_rd  [NUM_CKPT];
  logic [ROB_W-1:0]  ckpt_rob [NUM_CKPT];
  logic [CP_W-1:0]   ckpt_head_q, ckpt_tail_q;

  logic              writer, ckpted, fire, push;
  logic [FL_CW-1:0]  fl_count;
  logic [CP_W-1:0]   ckpt_count;
  logic [CKPT_W-1:0] mp_off;
  logic [PREG_W-1:0] pop_pd;

  // Decode, occupancy, handshake and the post-rename map for this cycle.
  always_comb begin
    writer     = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
    ckpted     = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    if (fl_wr_q.wrap == fl_rd_q.wrap) begin
      fl_count = FL_CW'(fl_wr_q.idx) - FL_CW'(fl_rd_q.idx);
    end else begin
      fl_count = FL_CW'(FL_DEPTH) - FL_CW'(fl_rd_q.idx) + FL_CW'(fl_wr_q.idx);
    end
    ckpt_count = ckpt_tail_q - ckpt_head_q;
    mp_off     = mispredict_tag - ckpt_head_q[CKPT_W-1:0];
    ready_in   = !mispredict && (!valid_out || ready_out) &&
                 (!writer || (fl_count != '0)) &&
                 (!ckpted || (ckpt_count != CP_W'(NUM_CKPT)));
    fire       = valid_in && ready_in;
    push       = commit_valid && (commit_pd_old != '0);
    pop_pd     = fl_mem[fl_rd_q.idx];
    fl_rd_nxt  = fl_rd_q;
    map_nxt    = map_q;
    if (fire && writer) begin
      fl_rd_nxt   = fl_inc(fl_rd_q);
      map_nxt[rd] = pop_pd;
    end
  end

  // Rename map: identity at reset, rolled back on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) map_q[i] <= PREG_W'(i);
    end else if (mispredict) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) map_q[i] <= ckpt_map[mispredict_tag][i];
    end else begin
      for (int i = 0; i < int'(ARCH_REGS); i++) map_q[i] <= map_nxt[i];
    end
  end

  // Free list: commits push at the write pointer, which is never rolled back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FL_DEPTH); i++) fl_mem[i] <= PREG_W'(int'(ARCH_REGS) + i);
      fl_rd_q <= '0;
      fl_wr_q <= '{wrap: 1'b1, idx: '0};
    end else begin
      if (push) begin
        fl_mem[fl_wr_q.idx] <= commit_pd_old;
        fl_wr_q             <= fl_inc(fl_wr_q);
      end
      fl_rd_q <= mispredict ? ckpt_rd[mispredict_tag] : fl_rd_nxt;
    end
  end

  // ROB tag counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rob_q <= '0;
    end else if (mispredict) begin
      rob_q <= ckpt_rob[mispredict_tag];
    end else if (fire) begin
      rob_q <= rob_q + ROB_W'(1);
    end
  end

  // Checkpoint ring: allocate at tail, resolve in order at head, truncate on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ckpt_head_q <= '0;
      ckpt_tail_q <= '0;
      for (int c = 0; c < int'(NUM_CKPT); c++) begin
        ckpt_rd[c]  <= '0;
        ckpt_rob[c] <= '0;
        for (int i = 0; i < int'(ARCH_REGS); i++) ckpt_map[c][i] <= '0;
      end
    end else if (mispredict) begin
      ckpt_tail_q <= ckpt_head_q + CP_W'(mp_off) + CP_W'(1);
    end else begin
      if (fire && ckpted) begin
        for (int i = 0; i < int'(ARCH_REGS); i++) ckpt_map[ckpt_tail_q[CKPT_W-1:0]][i] <= map_nxt[i];
        ckpt_rd[ckpt_tail_q[CKPT_W-1:0]]  <= fl_rd_nxt;
        ckpt_rob[ckpt_tail_q[CKPT_W-1:0]] <= rob_q + ROB_W'(1);
        ckpt_tail_q <= ckpt_tail_q + CP_W'(1);
      end
      if (resolve_valid) begin
        ckpt_head_q <= ckpt_head_q + CP_W'(1);
      end
    end
  end

  // Output register: loads on fire, drains on ready_out, flushed on mispredict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      ps1       <= '0;
      ps2       <= '0;
      pd_new    <= '0;
      pd_old    <= '0;
      imm_out   <= '0;
      rob_tag   <= '0;
      br_valid  <= 1'b0;
      br_tag    <= '0;
    end else if (mispredict) begin
      valid_out <= 1'b0;
    end else if (fire) begin
      valid_out <= 1'b1;
      ps1       <= map_q[rs1];
      ps2       <= map_q[rs2];
      pd_new    <= writer ? pop_pd : '0;
      pd_old    <= writer ? map_q[rd] : '0;
      imm_out   <= imm_in;
      rob_tag   <= rob_q;
      br_valid  <= ckpted;
      br_tag    <= ckpted ? ckpt_tail_q[CKPT_W-1:0] : '0;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

  // Illegal-input checks.
  a_resolve_live : assert property (@(posedge clk) disable iff (!reset)
    (resolve_valid || mispredict) |-> (ckpt_count != '0));
  a_mp_tag_live : assert property (@(posedge clk) disable iff (!reset)
    mispredict |-> (CP_W'(mp_off) < ckpt_count));
  a_push_not_full : assert property (@(posedge clk) disable iff (!reset)
    push |-> (fl_count != FL_CW'(FL_DEPTH)));

endmodule
